// File: rtl/counter_updown_mod.sv
// Parametrised up/down counter with prescaler, wrap/saturate limits,
// synchronous load/clear, terminal-count pulse and sticky limit flags.
module counter_updown_mod #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             overflow,
  output logic             underflow
);

  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);
  localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MODULUS - 1);

  logic [PSW-1:0]   ps_cnt;
  logic [PSW-1:0]   ps_d;
  logic [WIDTH-1:0] count_d;
  logic             tc_d;
  logic             ov_d;
  logic             un_d;

  logic             step;
  logic             at_top;
  logic             at_bot;
  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   up_nxt;
  logic [WIDTH:0]   dn_nxt;
  logic [WIDTH:0]   ld_ext;
  logic [WIDTH:0]   ld_clamp;

  // One extra bit keeps MODULUS == 2**WIDTH compares exact.
  assign cnt_ext  = {1'b0, count};
  assign up_nxt   = cnt_ext + (WIDTH+1)'(1);
  assign dn_nxt   = cnt_ext - (WIDTH+1)'(1);
  assign ld_ext   = {1'b0, load_value};
  assign ld_clamp = (ld_ext > MAXV) ? MAXV : ld_ext;
  assign at_top   = (cnt_ext == MAXV);
  assign at_bot   = (count == '0);
  assign step     = enable && (ps_cnt == PS_LAST);

  always_comb begin
    count_d = count;
    ps_d    = ps_cnt;
    tc_d    = 1'b0;
    ov_d    = overflow;
    un_d    = underflow;
    if (clear) begin
      count_d = '0;
      ps_d    = '0;
      ov_d    = 1'b0;
      un_d    = 1'b0;
    end else if (load) begin
      count_d = WIDTH'(ld_clamp);
      ps_d    = '0;
    end else if (enable) begin
      ps_d = step ? '0 : ps_cnt + PSW'(1);
      if (step) begin
        if (up_down) begin
          if (at_top) begin
            tc_d    = 1'b1;
            ov_d    = 1'b1;
            count_d = (SATURATE != 0) ? count : '0;
          end else begin
            count_d = WIDTH'(up_nxt);
          end
        end else begin
          if (at_bot) begin
            tc_d    = 1'b1;
            un_d    = 1'b1;
            count_d = (SATURATE != 0) ? count : WIDTH'(MAXV);
          end else begin
            count_d = WIDTH'(dn_nxt);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      ps_cnt    <= '0;
      tc        <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_d;
      ps_cnt    <= ps_d;
      tc        <= tc_d;
      overflow  <= ov_d;
      underflow <= un_d;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed scoreboard bench for counter_updown_mod over four
// parameterisations sharing one set of control inputs.
module tb_counter_updown_mod;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       up_down;
  logic       clear;
  logic       load;
  logic [3:0] load_value;

  logic [3:0] cnt [4];
  logic       tcv [4];
  logic       ov  [4];
  logic       un  [4];

  typedef struct {
    int         id;
    string      tag;
    logic [3:0] c;
    logic       t;
    logic       o;
    logic       u;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  counter_updown_mod u_def (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value),
    .count(cnt[0]), .tc(tcv[0]), .overflow(ov[0]), .underflow(un[0])
  );

  counter_updown_mod #(.MODULUS(10)) u_m10 (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value),
    .count(cnt[1]), .tc(tcv[1]), .overflow(ov[1]), .underflow(un[1])
  );

  counter_updown_mod #(.MODULUS(10), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value),
    .count(cnt[2]), .tc(tcv[2]), .overflow(ov[2]), .underflow(un[2])
  );

  counter_updown_mod #(.PRESCALE(3)) u_ps3 (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value),
    .count(cnt[3]), .tc(tcv[3]), .overflow(ov[3]), .underflow(un[3])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input string tag, input logic [3:0] c,
                      input logic t, input logic o, input logic u);
    exp_t e;
    e.id  = id;
    e.tag = tag;
    e.c   = c;
    e.t   = t;
    e.o   = o;
    e.u   = u;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t       e;
    logic [6:0] obs;
    logic [6:0] want;
    while (sb.size() > 0) begin
      e    = sb.pop_front();
      obs  = {cnt[e.id], tcv[e.id], ov[e.id], un[e.id]};
      want = {e.c, e.t, e.o, e.u};
      checks++;
      assert (obs === want) else begin
        errors++;
        $error("FAIL %s inst%0d: got c=%0d tc=%b ov=%b un=%b want c=%0d tc=%b ov=%b un=%b",
               e.tag, e.id, obs[6:3], obs[2], obs[1], obs[0],
               want[6:3], want[2], want[1], want[0]);
      end
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    enable     = 1'b0;
    up_down    = 1'b1;
    clear      = 1'b0;
    load       = 1'b0;
    load_value = '0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) push(i, "reset", 4'd0, 0, 0, 0);
    check();
  endtask

  initial begin
    do_reset();

    // Full wrap sweep on the default counter.
    enable  = 1'b1;
    up_down = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      push(0, "sweep", 4'(i % 16), (i == 16), (i >= 16), 1'b0);
      check();
    end

    // Underflow from zero: wrap vs saturate.
    do_reset();
    enable  = 1'b1;
    up_down = 1'b0;
    tick();
    push(1, "under_wrap", 4'd9, 1, 0, 1);
    push(2, "under_sat", 4'd0, 1, 0, 1);
    check();
    enable = 1'b0;
    tick();
    push(1, "under_tc_drop", 4'd9, 0, 0, 1);
    check();

    // Clamped load and repeated saturation.
    do_reset();
    load       = 1'b1;
    load_value = 4'd12;
    enable     = 1'b1;
    tick();
    push(2, "load_clamp", 4'd9, 0, 0, 0);
    push(1, "load_clamp_w", 4'd9, 0, 0, 0);
    check();
    load    = 1'b0;
    up_down = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      push(2, "sat_hold", 4'd9, 1, 1, 0);
      push(1, "wrap_up", 4'(i), (i == 0), 1, 0);
      check();
    end
    enable = 1'b0;
    tick();
    push(2, "sat_tc_drop", 4'd9, 0, 1, 0);
    check();

    // Prescale-by-3 with a gap in enable and direction wiggle off-step.
    do_reset();
    begin
      logic [6:0] en_pat;
      logic [3:0] want_c [7];
      en_pat = 7'b1011111;
      want_c = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
      for (int i = 0; i < 7; i++) begin
        enable  = en_pat[6-i];
        up_down = (i == 4) ? 1'b0 : 1'b1;
        tick();
        push(3, "prescale", want_c[i], 0, 0, 0);
        check();
      end
    end

    // Clear beats load; load alone; clear beats a limit step.
    do_reset();
    enable  = 1'b1;
    up_down = 1'b0;
    tick();
    push(0, "pre_flag", 4'd15, 1, 0, 1);
    check();
    enable     = 1'b0;
    load       = 1'b1;
    clear      = 1'b1;
    load_value = 4'd5;
    tick();
    push(0, "clear_over_load", 4'd0, 0, 0, 0);
    check();
    clear = 1'b0;
    tick();
    push(0, "load_only", 4'd5, 0, 0, 0);
    check();
    load_value = 4'd15;
    enable     = 1'b1;
    up_down    = 1'b1;
    tick();
    push(0, "load_ignores_en", 4'd15, 0, 0, 0);
    check();
    load  = 1'b0;
    clear = 1'b1;
    tick();
    push(0, "clear_over_step", 4'd0, 0, 0, 0);
    check();
    clear = 1'b0;

    // Asynchronous reset mid-prescale, then resume.
    do_reset();
    enable  = 1'b1;
    up_down = 1'b1;
    for (int i = 0; i < 22; i++) tick();
    push(3, "pre_async", 4'd7, 0, 0, 0);
    push(0, "pre_async_def", 4'd6, 0, 1, 0);
    check();
    #2 reset = 1'b1;
    #1;
    push(3, "async_rst", 4'd0, 0, 0, 0);
    push(0, "async_rst_def", 4'd0, 0, 0, 0);
    check();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    push(3, "resume", 4'd1, 0, 0, 0);
    push(0, "resume_def", 4'd3, 0, 0, 0);
    check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
